// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter over 8 requesters feeding a 3-to-8 decoder select/enable.
// Optional grant hold timeout is compiled in with `define ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic       dec_en,
    output logic       grant_valid,
    output logic       timeout
);

    // Handshake: req[i] asks for the decoder; the grantee keeps req high while
    // it uses the grant and ends it with done=1 or by dropping req. A grant is
    // live (sel valid) exactly while grant_valid=1; every grant is followed by
    // one dead GAP cycle before the next grant can start.

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("HOLD_MAX must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic       dec_en_q, dec_en_d;
    logic       found;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       released;

    // Circular search starting just after the last grantee, ending on it.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = ptr_q;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign released = done || !req[sel_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE, GAP: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    ptr_d   = winner;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // A real release always takes precedence over expiry.
                if (released) begin
                    state_d = GAP;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_cnt_q == 8'(HOLD_MAX - 1)) begin
                    state_d   = GAP;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        dec_en_d = (state_d == GRANT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 3'd7;
            sel_q    <= 3'd0;
            dec_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            dec_en_q <= dec_en_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign sel         = sel_q;
    assign dec_en      = dec_en_q;
    assign grant_valid = dec_en_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural round-robin model.
module tb_decoder_rr_arbiter;

  localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] sel;
  logic       dec_en;
  logic       grant_valid;
  logic       timeout;

  always #5 clk = ~clk;

  decoder_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .sel         (sel),
    .dec_en      (dec_en),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // behavioural model: who holds the grant, how long, who went last
  bit m_granted;
  int m_owner;
  int m_last;
  int m_len;
  bit m_to;

  always @(posedge clk) begin
    if (rst) begin
      m_granted = 1'b0;
      m_owner   = 0;
      m_last    = 7;
      m_len     = 0;
      m_to      = 1'b0;
    end else if (m_granted) begin
      m_to = 1'b0;
      if (done || !req[m_owner]) begin
        m_granted = 1'b0;
      end else if (TO_EN && m_len == HOLD) begin
        m_granted = 1'b0;
        m_to      = 1'b1;
      end else begin
        m_len++;
      end
    end else begin
      m_to = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        if (!m_granted && req[(m_last + k) % 8]) begin
          m_granted = 1'b1;
          m_owner   = (m_last + k) % 8;
          m_last    = m_owner;
          m_len     = 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare every cycle against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sel", int'(sel), m_owner);
      check("model_dec_en", int'(dec_en), int'(m_granted));
      check("model_grant_valid", int'(grant_valid), int'(m_granted));
      check("model_timeout", int'(timeout), int'(m_to));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    req = 8'h00;
  endtask

  initial begin
    // reset state
    do_reset();
    chk_en = 1'b1;
    check("reset_sel", int'(sel), 0);
    check("reset_gv", int'(grant_valid), 0);
    check("reset_to", int'(timeout), 0);

    // reset priority: 0x84 -> 2, then 7
    req = 8'h84; tick();
    check("prio_sel2", int'(sel), 2);
    check("prio_gv", int'(grant_valid), 1);
    done = 1'b1; tick();
    check("prio_gap_en", int'(dec_en), 0);
    check("prio_gap_sel", int'(sel), 2);
    done = 1'b0; tick();
    check("prio_sel7", int'(sel), 7);
    check("prio_gv7", int'(grant_valid), 1);

    // rotation over all requesters
    do_reset();
    req = 8'hFF; tick();
    check("rot_sel0", int'(sel), 0);
    for (int i = 1; i <= 8; i++) begin
      done = 1'b1; tick();
      check("rot_gap", int'(dec_en), 0);
      done = 1'b0; tick();
      check("rot_sel", int'(sel), i % 8);
      check("rot_gv", int'(grant_valid), 1);
    end

    // sole requester re-grant
    do_reset();
    req = 8'h20; tick();
    check("sole_sel", int'(sel), 5);
    done = 1'b1; tick();
    check("sole_gap", int'(dec_en), 0);
    done = 1'b0; tick();
    check("sole_regrant", int'(sel), 5);
    check("sole_gv", int'(dec_en), 1);

    // mid-grant reset
    do_reset();
    req = 8'h40; tick();
    check("mid_sel6", int'(sel), 6);
    rst = 1'b1; tick();
    check("mid_rst_sel", int'(sel), 0);
    check("mid_rst_gv", int'(grant_valid), 0);
    check("mid_rst_en", int'(dec_en), 0);
    rst = 1'b0; req = 8'h41; tick();
    check("mid_after_sel", int'(sel), 0);
    check("mid_after_gv", int'(grant_valid), 1);

    // hold timeout (or unbounded grant without it)
    do_reset();
    req = 8'h08;
    for (int c = 1; c <= HOLD; c++) begin
      tick();
      check("hold_gv", int'(grant_valid), 1);
      check("hold_sel", int'(sel), 3);
      check("hold_to", int'(timeout), 0);
    end
    tick();
    check("hold_end_gv", int'(grant_valid), TO_EN ? 0 : 1);
    check("hold_end_to", int'(timeout), TO_EN ? 1 : 0);
    tick();
    check("hold_regrant_sel", int'(sel), 3);
    check("hold_regrant_gv", int'(grant_valid), 1);
    check("hold_regrant_to", int'(timeout), 0);

    // release by req drop
    do_reset();
    req = 8'h02; tick();
    check("drop_sel1", int'(sel), 1);
    req = 8'h00; tick();
    check("drop_gap", int'(grant_valid), 0);
    check("drop_to", int'(timeout), 0);
    tick();
    check("drop_idle", int'(grant_valid), 0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: req = 8'($urandom_range(0, 255));
          1: req = 8'(1 << $urandom_range(0, 7));
          default: req = 8'h00;
        endcase
      end
      done = ($urandom_range(0, 4) == 0);
      tick();
    end

    rst = 1'b0; req = 8'h00; done = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
